// File: rtl/sink_id_arbiter.sv
// rtl/sink_id_arbiter.sv - shares one sink ID manager between allocating requesters and release sources
//
// Purpose: round-robin arbitration of sink ID allocation requests onto the
// manager's one-cycle alloc handshake (retrying while the pool is exhausted),
// per-ID owner tracking with a per-requester outstanding limit, and
// round-robin serialisation of releases onto the manager's dealloc port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req / gnt, gnt_sink_id   requester level requests, one-hot grant pulse + ID
//   rel_valid / rel_ready    release handshake per source, rel_sink_id packed IDs
//   mgr_alloc_*              alloc handshake to/from the sink ID manager
//   mgr_dealloc_*            registered dealloc pulse to the manager
//   busy                     allocation FSM not idle
//   err_bad_release          sticky: a release named an unowned ID

`ifndef WSINK
`define WSINK 2
`endif

module sink_id_arbiter #(
  parameter int NREQ        = 4,
  parameter int NREL        = 2,
  parameter int MAX_PER_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          gnt,
  output logic [`WSINK-1:0]        gnt_sink_id,
  input  logic [NREL-1:0]          rel_valid,
  input  logic [NREL*`WSINK-1:0]   rel_sink_id,
  output logic [NREL-1:0]          rel_ready,
  output logic                     mgr_alloc_req,
  input  logic                     mgr_alloc_gnt,
  input  logic [`WSINK-1:0]        mgr_alloc_sink_id,
  output logic                     mgr_dealloc_req,
  output logic [`WSINK-1:0]        mgr_dealloc_sink_id,
  output logic                     busy,
  output logic                     err_bad_release
);

  localparam int WS  = `WSINK;
  localparam int NID = 1 << WS;
  localparam int WI  = $clog2(NREQ);
  localparam int WR  = (NREL > 1) ? $clog2(NREL) : 1;
  localparam int WC  = $clog2(MAX_PER_REQ + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [WI-1:0]     winner_q, winner_d;
  logic [WS-1:0]     cand_id_q, cand_id_d;
  logic [WI-1:0]     alloc_rr_q, alloc_rr_d;
  logic [WR-1:0]     rel_rr_q, rel_rr_d;
  logic [WC-1:0]     count_q [NREQ];
  logic [WC-1:0]     count_d [NREQ];
  logic [NID-1:0]    owned_q, owned_d;
  logic [WI-1:0]     owner_q [NID];
  logic [WI-1:0]     owner_d [NID];
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WS-1:0]     gnt_sink_id_q, gnt_sink_id_d;
  logic              dealloc_req_q, dealloc_req_d;
  logic [WS-1:0]     dealloc_id_q, dealloc_id_d;
  logic              err_q, err_d;

  logic              elig_any;
  logic [WI-1:0]     pick, pos;
  logic              rel_any;
  logic [WR-1:0]     rel_sel, rel_pos;
  logic [WS-1:0]     rel_id;
  logic [WS-1:0]     rel_ids [NREL];
  logic [NREQ-1:0]   inc, dec;

  for (genvar j = 0; j < NREL; j++) begin : g_rel_unpack
    assign rel_ids[j] = rel_sink_id[j*WS +: WS];
  end

  // First eligible requester at or after alloc_rr, wrapping.
  always_comb begin
    elig_any = 1'b0;
    pick     = '0;
    pos      = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = WI'((int'(alloc_rr_q) + k) % NREQ);
      if (!elig_any && req[pos] && (count_q[pos] < WC'(MAX_PER_REQ))) begin
        elig_any = 1'b1;
        pick     = pos;
      end
    end
  end

  // First valid release source at or after rel_rr, wrapping.
  always_comb begin
    rel_any   = 1'b0;
    rel_sel   = '0;
    rel_pos   = '0;
    rel_ready = '0;
    for (int k = 0; k < NREL; k++) begin
      rel_pos = WR'((int'(rel_rr_q) + k) % NREL);
      if (!rel_any && rel_valid[rel_pos]) begin
        rel_any = 1'b1;
        rel_sel = rel_pos;
      end
    end
    if (rel_any) rel_ready[rel_sel] = 1'b1;
    rel_id = rel_ids[rel_sel];
  end

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    cand_id_d     = cand_id_q;
    alloc_rr_d    = alloc_rr_q;
    rel_rr_d      = rel_rr_q;
    owned_d       = owned_q;
    owner_d       = owner_q;
    gnt_d         = '0;
    gnt_sink_id_d = gnt_sink_id_q;
    dealloc_req_d = 1'b0;
    dealloc_id_d  = dealloc_id_q;
    err_d         = err_q;
    inc           = '0;
    dec           = '0;

    case (state_q)
      IDLE: begin
        if (elig_any) begin
          winner_d = pick;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cand_id_d = mgr_alloc_sink_id;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mgr_alloc_gnt) begin
          gnt_d[winner_q]    = 1'b1;
          gnt_sink_id_d      = cand_id_q;
          owned_d[cand_id_q] = 1'b1;
          owner_d[cand_id_q] = winner_q;
          inc[winner_q]      = 1'b1;
          alloc_rr_d         = (winner_q == WI'(NREQ - 1)) ? '0 : winner_q + 1'b1;
          state_d            = IDLE;
        end else begin
          // Pool exhausted: re-issue for the same winner.
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Releases are consumed whether or not the ID is owned; unowned ones
    // only raise the sticky error so counters can never underflow.
    if (rel_any) begin
      if (owned_q[rel_id]) begin
        owned_d[rel_id]       = 1'b0;
        dec[owner_q[rel_id]]  = 1'b1;
        dealloc_req_d         = 1'b1;
        dealloc_id_d          = rel_id;
        rel_rr_d              = (rel_sel == WR'(NREL - 1)) ? '0 : rel_sel + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    for (int i = 0; i < NREQ; i++) begin
      count_d[i] = count_q[i] + WC'(inc[i]) - WC'(dec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      winner_q      <= '0;
      cand_id_q     <= '0;
      alloc_rr_q    <= '0;
      rel_rr_q      <= '0;
      owned_q       <= '0;
      gnt_q         <= '0;
      gnt_sink_id_q <= '0;
      dealloc_req_q <= 1'b0;
      dealloc_id_q  <= '0;
      err_q         <= 1'b0;
      for (int i = 0; i < NREQ; i++) count_q[i] <= '0;
      for (int i = 0; i < NID; i++) owner_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      cand_id_q     <= cand_id_d;
      alloc_rr_q    <= alloc_rr_d;
      rel_rr_q      <= rel_rr_d;
      owned_q       <= owned_d;
      gnt_q         <= gnt_d;
      gnt_sink_id_q <= gnt_sink_id_d;
      dealloc_req_q <= dealloc_req_d;
      dealloc_id_q  <= dealloc_id_d;
      err_q         <= err_d;
      for (int i = 0; i < NREQ; i++) count_q[i] <= count_d[i];
      for (int i = 0; i < NID; i++) owner_q[i] <= owner_d[i];
    end
  end

  assign gnt                 = gnt_q;
  assign gnt_sink_id         = gnt_sink_id_q;
  assign mgr_alloc_req       = (state_q == ISSUE);
  assign mgr_dealloc_req     = dealloc_req_q;
  assign mgr_dealloc_sink_id = dealloc_id_q;
  assign busy                = (state_q != IDLE);
  assign err_bad_release     = err_q;

endmodule

// File: tb/tb_sink_id_arbiter.sv
// tb/tb_sink_id_arbiter.sv - scoreboard bench for sink_id_arbiter

`ifndef WSINK
`define WSINK 2
`endif

module tb_sink_id_arbiter;
  localparam int NREQ = 4;
  localparam int NREL = 2;
  localparam int MAXR = 2;
  localparam int WS   = `WSINK;
  localparam int NID  = 1 << WS;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      gnt;
  logic [WS-1:0]        gnt_sink_id;
  logic [NREL-1:0]      rel_valid;
  logic [NREL*WS-1:0]   rel_sink_id;
  logic [NREL-1:0]      rel_ready;
  logic                 mgr_alloc_req;
  logic                 mgr_alloc_gnt;
  logic [WS-1:0]        mgr_alloc_sink_id;
  logic                 mgr_dealloc_req;
  logic [WS-1:0]        mgr_dealloc_sink_id;
  logic                 busy;
  logic                 err_bad_release;

  int checks = 0;
  int errors = 0;

  typedef struct {int r; int id;} gexp_t;
  gexp_t exp_gnt[$];
  int    exp_dealloc[$];

  sink_id_arbiter #(.NREQ(NREQ), .NREL(NREL), .MAX_PER_REQ(MAXR)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_sink_id(gnt_sink_id),
    .rel_valid(rel_valid), .rel_sink_id(rel_sink_id), .rel_ready(rel_ready),
    .mgr_alloc_req(mgr_alloc_req), .mgr_alloc_gnt(mgr_alloc_gnt),
    .mgr_alloc_sink_id(mgr_alloc_sink_id), .mgr_dealloc_req(mgr_dealloc_req),
    .mgr_dealloc_sink_id(mgr_dealloc_sink_id), .busy(busy),
    .err_bad_release(err_bad_release)
  );

  always #5 clk = ~clk;

  // Sink ID manager model: lowest free ID offered, grant one cycle after alloc_req.
  logic [NID-1:0] mgr_map;
  always_comb begin
    mgr_alloc_sink_id = '0;
    for (int i = NID - 1; i >= 0; i--) if (!mgr_map[i]) mgr_alloc_sink_id = WS'(i);
  end
  always @(posedge clk) begin
    if (rst) begin
      mgr_map       <= '0;
      mgr_alloc_gnt <= 1'b0;
    end else begin
      mgr_alloc_gnt <= mgr_alloc_req && !(&mgr_map);
      if (mgr_alloc_req && !(&mgr_map)) mgr_map[mgr_alloc_sink_id] <= 1'b1;
      if (mgr_dealloc_req) mgr_map[mgr_dealloc_sink_id] <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop expected grants / deallocs whenever the DUT presents one.
  always @(negedge clk) begin
    if (!rst && gnt != '0) begin
      if (exp_gnt.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'h0);
      else begin
        gexp_t e;
        e = exp_gnt.pop_front();
        chk("gnt_onehot", 32'(gnt), 32'(1) << e.r);
        chk("gnt_sink_id", 32'(gnt_sink_id), 32'(e.id));
      end
    end
    if (!rst && mgr_dealloc_req) begin
      if (exp_dealloc.size() == 0) chk("dealloc_unexpected", 32'(mgr_dealloc_sink_id), 32'hffff);
      else chk("dealloc_id", 32'(mgr_dealloc_sink_id), 32'(exp_dealloc.pop_front()));
    end
  end

  task automatic do_reset();
    rst = 1'b1; req = '0; rel_valid = '0; rel_sink_id = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_gnt.size() != 0 || exp_dealloc.size() != 0) && n < budget) begin
      @(negedge clk); #1; n++;
    end
    chk("drain_gnt", 32'(exp_gnt.size()), 32'h0);
    chk("drain_dealloc", 32'(exp_dealloc.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    do_reset();
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_gnt_id", 32'(gnt_sink_id), 0);
    chk("rst_alloc_req", 32'(mgr_alloc_req), 0);
    chk("rst_dealloc", 32'(mgr_dealloc_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_bad_release), 0);
    chk("rst_rel_ready", 32'(rel_ready), 0);

    // Single requester latency and back-to-back grant.
    @(posedge clk); #1 req = 4'b0001;
    exp_gnt.push_back('{0, 0});
    exp_gnt.push_back('{0, 1});
    @(negedge clk); chk("c0_alloc_req", 32'(mgr_alloc_req), 0);
    @(negedge clk); chk("c1_alloc_req", 32'(mgr_alloc_req), 1);
    @(negedge clk); chk("c2_busy", 32'(busy), 1); chk("c2_gnt", 32'(gnt), 0);
    @(negedge clk); chk("c3_gnt", 32'(gnt), 1); chk("c3_id", 32'(gnt_sink_id), 0);
    repeat (3) @(negedge clk);
    chk("c6_gnt", 32'(gnt), 1); chk("c6_id", 32'(gnt_sink_id), 1);
    req = '0;
    wait_drain(20);

    // All four held: 0,1,2,3 then pool full and ISSUE/WAIT alternate.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) exp_gnt.push_back('{i, i});
    wait_drain(60);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("full_busy", 32'(busy), 1);
      if (mgr_alloc_req) n++;
    end
    chk("full_retry_count", 32'(n), 3);
    @(posedge clk); #1 rel_valid = 2'b01; rel_sink_id = {2'd0, 2'd2};
    exp_dealloc.push_back(2);
    exp_gnt.push_back('{0, 2});
    @(negedge clk); chk("rel2_ready", 32'(rel_ready), 32'b01); chk("rel2_pre_dealloc", 32'(mgr_dealloc_req), 0);
    @(posedge clk); #1 rel_valid = '0;
    @(negedge clk); chk("rel2_dealloc", 32'(mgr_dealloc_req), 1);
    wait_drain(30);

    // Per-requester limit with only req[1].
    do_reset();
    req = 4'b0010;
    exp_gnt.push_back('{1, 0});
    exp_gnt.push_back('{1, 1});
    wait_drain(30);
    repeat (6) @(negedge clk);
    chk("limit_idle_busy", 32'(busy), 0);
    @(posedge clk); #1 rel_valid = 2'b10; rel_sink_id = {2'd0, 2'd3};
    exp_dealloc.push_back(0);
    exp_gnt.push_back('{1, 0});
    @(negedge clk); chk("limit_rel_ready", 32'(rel_ready), 32'b10);
    @(posedge clk); #1 rel_valid = '0;
    wait_drain(30);
    req = '0;

    // Two sources in the same cycle (IDs 0 and 1 owned by requester 1).
    @(posedge clk); #1 rel_valid = 2'b11; rel_sink_id = {2'd1, 2'd0};
    exp_dealloc.push_back(0);
    exp_dealloc.push_back(1);
    @(negedge clk); chk("dual_ready0", 32'(rel_ready), 32'b01);
    @(posedge clk); #1 rel_valid = 2'b10;
    @(negedge clk); chk("dual_ready1", 32'(rel_ready), 32'b10);
    chk("dual_dealloc0", 32'(mgr_dealloc_req), 1);
    @(posedge clk); #1 rel_valid = '0;
    @(negedge clk); chk("dual_dealloc1", 32'(mgr_dealloc_req), 1);
    wait_drain(10);

    // Unowned release: consumed, sticky error, no dealloc, counts intact.
    @(posedge clk); #1 rel_valid = 2'b01; rel_sink_id = {2'd0, 2'd3};
    @(negedge clk); chk("bad_ready", 32'(rel_ready), 32'b01);
    @(posedge clk); #1 rel_valid = '0;
    @(negedge clk); chk("bad_err", 32'(err_bad_release), 1); chk("bad_no_dealloc", 32'(mgr_dealloc_req), 0);
    repeat (4) @(negedge clk);
    chk("bad_err_sticky", 32'(err_bad_release), 1);
    req = 4'b0010;
    exp_gnt.push_back('{1, 0});
    exp_gnt.push_back('{1, 1});
    wait_drain(30);
    repeat (6) @(negedge clk);
    chk("bad_limit_busy", 32'(busy), 0);
    req = '0;

    // Reset while in WAIT.
    do_reset();
    @(negedge clk); chk("rst2_err", 32'(err_bad_release), 0);
    @(posedge clk); #1 req = 4'b0100;
    @(negedge clk);
    @(negedge clk); chk("w_issue", 32'(mgr_alloc_req), 1);
    @(negedge clk); chk("w_wait_busy", 32'(busy), 1); chk("w_wait_alloc", 32'(mgr_alloc_req), 0);
    rst = 1'b1; req = '0;
    @(negedge clk);
    chk("w_rst_gnt", 32'(gnt), 0);
    chk("w_rst_busy", 32'(busy), 0);
    chk("w_rst_alloc", 32'(mgr_alloc_req), 0);
    chk("w_rst_dealloc", 32'(mgr_dealloc_req), 0);
    chk("w_rst_err", 32'(err_bad_release), 0);
    rst = 1'b0; req = 4'b0100;
    exp_gnt.push_back('{2, 0});
    wait_drain(30);
    req = '0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
